// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache QSPI line-fill engine.
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_BURST,
        S_GAP
    } fill_state_t;

    localparam logic [7:0] QSPI_CMD_QREAD = 8'hEB;
    localparam int         ADDR_NIBBLES   = 6;
    localparam int         FLASH_ADDR_W   = 4 * ADDR_NIBBLES;
    localparam int         CMD_PERIODS    = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/icache_fill.sv
// Fetches one instruction-cache line from QSPI flash (quad read, 0xEB) and
// replays it to the cache as an unbroken run of nibble strobes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for pull; cs_n high, bus released
// S_CMD   | shifting the 0xEB command out on io_out[0]
// S_ADDR  | driving the 24-bit byte address, one nibble per period
// S_DUMMY | mode/dummy periods, bus released to the flash
// S_DATA  | sampling the line nibbles into rx_buf
// S_BURST | cs_n high, one wstrobe_d per clk for the whole line
// S_GAP   | two-clk hold-off so the cache hit can settle before re-arming
module icache_fill
    import icache_pkg::*;
#(
    parameter int PA          = 22,
    parameter int LINE_LENGTH = 4,
    parameter int DUMMY       = 6
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               pull,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0]  tag,
    output logic [3:0]                         dread,
    output logic                               wstrobe_d,
    output logic                               busy,
    output logic                               sclk,
    output logic                               cs_n,
    output logic [3:0]                         io_out,
    output logic [3:0]                         io_oe,
    input  logic [3:0]                         io_in
);

    localparam int OFF_W   = $clog2(LINE_LENGTH);
    localparam int NIBBLES = 2 * LINE_LENGTH;
    localparam int BUF_W   = 4 * NIBBLES;
    localparam int TX_W    = 8 + FLASH_ADDR_W;
    localparam int CNT_W   = $clog2(max3(CMD_PERIODS, DUMMY, NIBBLES) + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(CMD_PERIODS);
    localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(ADDR_NIBBLES);
    localparam logic [CNT_W-1:0] CNT_DUMMY = CNT_W'(DUMMY);
    localparam logic [CNT_W-1:0] CNT_NIB   = CNT_W'(NIBBLES);
    localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(2);

    fill_state_t             state;
    logic                    phase;
    logic [CNT_W-1:0]        cnt;
    logic [TX_W-1:0]         tx_sr;
    logic [BUF_W-1:0]        rx_buf;
    logic [FLASH_ADDR_W-1:0] byte_addr;
    logic                    last;

    assign byte_addr = FLASH_ADDR_W'(tag) << OFF_W;
    assign last      = (cnt == CNT_ONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            phase     <= 1'b0;
            cnt       <= '0;
            tx_sr     <= '0;
            rx_buf    <= '0;
            dread     <= 4'h0;
            wstrobe_d <= 1'b0;
            busy      <= 1'b0;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            io_out    <= 4'h0;
            io_oe     <= 4'h0;
        end else begin
            wstrobe_d <= 1'b0;
            // Every serial state runs the same two-clk period; transitions happen at period end.
            if (state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA}) begin
                phase <= ~phase;
                sclk  <= ~phase;
            end
            case (state)
                S_IDLE: begin
                    if (pull) begin
                        state  <= S_CMD;
                        cnt    <= CNT_CMD;
                        tx_sr  <= {QSPI_CMD_QREAD[6:0], byte_addr, 1'b0};
                        io_out <= {3'b000, QSPI_CMD_QREAD[7]};
                        io_oe  <= 4'b0001;
                        cs_n   <= 1'b0;
                        busy   <= 1'b1;
                        phase  <= 1'b0;
                        sclk   <= 1'b0;
                    end
                end
                S_CMD: begin
                    if (phase) begin
                        if (last) begin
                            state  <= S_ADDR;
                            cnt    <= CNT_ADDR;
                            io_oe  <= 4'hF;
                            io_out <= tx_sr[TX_W-1 -: 4];
                            tx_sr  <= tx_sr << 4;
                        end else begin
                            cnt    <= cnt - CNT_ONE;
                            io_out <= {3'b000, tx_sr[TX_W-1]};
                            tx_sr  <= tx_sr << 1;
                        end
                    end
                end
                S_ADDR: begin
                    if (phase) begin
                        if (last) begin
                            state  <= S_DUMMY;
                            cnt    <= CNT_DUMMY;
                            io_oe  <= 4'h0;
                            io_out <= 4'h0;
                        end else begin
                            cnt    <= cnt - CNT_ONE;
                            io_out <= tx_sr[TX_W-1 -: 4];
                            tx_sr  <= tx_sr << 4;
                        end
                    end
                end
                S_DUMMY: begin
                    if (phase) begin
                        if (last) begin
                            state <= S_DATA;
                            cnt   <= CNT_NIB;
                        end else begin
                            cnt   <= cnt - CNT_ONE;
                        end
                    end
                end
                S_DATA: begin
                    if (phase) begin
                        rx_buf <= {rx_buf[BUF_W-5:0], io_in};
                        if (last) begin
                            state <= S_BURST;
                            cnt   <= CNT_NIB;
                            cs_n  <= 1'b1;
                        end else begin
                            cnt   <= cnt - CNT_ONE;
                        end
                    end
                end
                S_BURST: begin
                    wstrobe_d <= 1'b1;
                    dread     <= rx_buf[BUF_W-1 -: 4];
                    rx_buf    <= rx_buf << 4;
                    if (last) begin
                        state <= S_GAP;
                        cnt   <= CNT_GAP;
                    end else begin
                        cnt   <= cnt - CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (last) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cs_n  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fill.sv
// Self-checking bench for icache_fill: flash model on the QSPI pins, strobe scoreboard.
module tb_icache_fill;
    import icache_pkg::*;

    localparam int PA    = 22;
    localparam int LL    = 4;
    localparam int DMY   = 6;
    localparam int TW    = PA - $clog2(LL);
    localparam int NIB   = 2 * LL;
    localparam int FIRST = 57;
    localparam int DATA0 = 8 + ADDR_NIBBLES + DMY;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pull = 1'b0;
    logic [TW-1:0] tag = '0;
    logic [3:0]    dread;
    logic          wstrobe_d, busy, sclk, cs_n;
    logic [3:0]    io_out, io_oe;
    logic [3:0]    io_in = 4'h0;

    icache_fill #(.PA(PA), .LINE_LENGTH(LL), .DUMMY(DMY)) dut (
        .clk(clk), .reset(reset), .pull(pull), .tag(tag),
        .dread(dread), .wstrobe_d(wstrobe_d), .busy(busy),
        .sclk(sclk), .cs_n(cs_n), .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Flash model: counts SCLK periods from chip select, captures command/address, serves line data.
    int          n_sclk = 0;
    int          fills = 0;
    int          oe_err = 0;
    logic [7:0]  cmd_cap = '0;
    logic [23:0] addr_cap = '0;
    logic [31:0] fl_data = '0;

    always @(negedge cs_n) begin
        n_sclk = 0;
        cmd_cap = '0;
        addr_cap = '0;
        fills++;
    end

    always @(posedge sclk) begin
        int k;
        n_sclk++;
        if (n_sclk <= 8) begin
            cmd_cap = {cmd_cap[6:0], io_out[0]};
            if (io_oe !== 4'b0001) oe_err++;
        end else if (n_sclk <= 8 + ADDR_NIBBLES) begin
            addr_cap = {addr_cap[19:0], io_out};
            if (io_oe !== 4'hF) oe_err++;
        end else if (io_oe !== 4'h0) begin
            oe_err++;
        end
        k = n_sclk - DATA0 - 1;
        if (k >= 0 && k < NIB) io_in = fl_data[4*(NIB-1-k) +: 4];
        else io_in = 4'($urandom);
    end

    // Strobe scoreboard plus bus-idle and run-length protocol checks.
    typedef struct { int t; logic [3:0] d; } strobe_t;
    strobe_t sq[$];
    strobe_t s_tmp;
    int run = 0;
    int idle_err = 0;

    always @(negedge clk) begin
        if (wstrobe_d === 1'b1) begin
            s_tmp.t = cyc;
            s_tmp.d = dread;
            sq.push_back(s_tmp);
            run++;
        end else if (run != 0) begin
            check("run_length", run, NIB);
            run = 0;
        end
        if (cs_n === 1'b1 && (sclk !== 1'b0 || io_oe !== 4'h0)) idle_err++;
    end

    function automatic logic [3:0] nib_of(input logic [31:0] d, input int k);
        return d[4*(NIB-1-k) +: 4];
    endfunction

    task automatic wait_busy(input logic lvl, input int bound);
        int n;
        n = 0;
        while (busy !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_fill(input string nm, input logic [TW-1:0] t, input logic [31:0] d,
                           input logic [23:0] exp_addr);
        int t0;
        sq.delete();
        fl_data = d;
        @(negedge clk);
        pull = 1'b1;
        tag  = t;
        @(posedge clk);
        #1;
        t0 = cyc;
        check({nm, "_busy_rise"}, busy, 1);
        check({nm, "_cs_low"}, cs_n, 0);
        @(negedge clk);
        pull = 1'b0;
        tag  = TW'($urandom);
        wait_busy(1'b0, 200);
        check({nm, "_busy_fall"}, cyc - t0, FIRST + NIB + 1);
        check({nm, "_cmd"}, cmd_cap, 8'hEB);
        check({nm, "_addr"}, addr_cap, exp_addr);
        check({nm, "_strobes"}, sq.size(), NIB);
        for (int k = 0; k < NIB && k < sq.size(); k++) begin
            check($sformatf("%s_dread%0d", nm, k), sq[k].d, nib_of(d, k));
            check($sformatf("%s_time%0d", nm, k), sq[k].t - t0, FIRST + k);
        end
    endtask

    typedef struct { logic [TW-1:0] tag; logic [31:0] data; logic [23:0] addr; } vec_t;
    vec_t vecs[4];

    initial begin
        logic [TW-1:0] ta, tb2;
        logic [31:0]   dr;
        int            t0, f0, rel;

        vecs[0] = '{tag: 20'h00123, data: 32'h12345678, addr: 24'h00048C};
        vecs[1] = '{tag: 20'h00004, data: 32'hDEADBEEF, addr: 24'h000010};
        vecs[2] = '{tag: 20'hFFFFF, data: 32'h0F0F0F0F, addr: 24'h3FFFFC};
        vecs[3] = '{tag: 20'h00000, data: 32'hA5C3E781, addr: 24'h000000};

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_io_oe", io_oe, 0);
        check("rst_io_out", io_out, 0);
        check("rst_wstrobe", wstrobe_d, 0);
        check("rst_dread", dread, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) do_fill($sformatf("vec%0d", i), vecs[i].tag, vecs[i].data, vecs[i].addr);

        for (int i = 0; i < 6; i++) begin
            ta = TW'($urandom);
            dr = $urandom;
            do_fill($sformatf("rnd%0d", i), ta, dr, 24'(int'(ta) * LL));
        end

        // Pull held across GAP: the same miss restarts exactly once, two clk after the burst.
        sq.delete();
        fl_data = 32'hCAFE1234;
        f0 = fills;
        @(negedge clk);
        pull = 1'b1;
        tag  = 20'h00ABC;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        wait_busy(1'b0, 200);
        check("b2b_first_end", cyc - t0, FIRST + NIB + 1);
        wait_busy(1'b1, 10);
        check("b2b_restart", cyc - t0, FIRST + NIB + 2);
        check("b2b_fills_mid", fills - f0, 2);
        pull = 1'b0;
        @(negedge clk);
        wait_busy(1'b0, 200);
        check("b2b_strobes", sq.size(), 2 * NIB);
        if (sq.size() > NIB) check("b2b_second_first", sq[NIB].t - t0, FIRST + NIB + 2 + FIRST);
        repeat (80) @(negedge clk);
        check("b2b_fills_end", fills - f0, 2);

        // Pull pulses with a different tag inside CMD, DATA, BURST and GAP are ignored.
        sq.delete();
        fl_data = 32'h87654321;
        ta  = 20'h5A5A5;
        tb2 = 20'h0F00F;
        f0  = fills;
        @(negedge clk);
        pull = 1'b1;
        tag  = ta;
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (rel == 5 || rel == 45 || rel == 60 || rel == 64 || rel == 65) begin
                pull = 1'b1;
                tag  = tb2;
            end else begin
                pull = 1'b0;
                tag  = ta;
            end
        end
        check("ign_fills", fills - f0, 1);
        check("ign_addr", addr_cap, 24'(int'(ta) * LL));
        check("ign_strobes", sq.size(), NIB);
        if (sq.size() > 0) check("ign_first_nib", sq[0].d, 4'h8);

        // Reset mid-DATA aborts the fill; nothing is strobed until a new pull.
        sq.delete();
        fl_data = 32'h11112222;
        f0 = fills;
        @(negedge clk);
        pull = 1'b1;
        tag  = 20'h00777;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        pull = 1'b0;
        while (cyc - t0 < DATA0 * 2 + 5 && cyc - t0 < 200) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_cs_n", cs_n, 1);
        check("abort_io_oe", io_oe, 0);
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_no_strobe", sq.size(), 0);
        check("abort_fills", fills - f0, 1);
        check("abort_idle", busy, 0);
        do_fill("after_abort", 20'h00321, 32'h9ABCDEF0, 24'h000C84);

        check("idle_protocol", idle_err, 0);
        check("io_oe_protocol", oe_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/icache_fill.md
ICACHE_FILL -- requirements
Module: icache_fill

Interface
REQ-001 Parameter PA, default 22: physical address width, matching the instruction cache.
REQ-002 Parameter LINE_LENGTH, default 4: cache line bytes; the block transfers 2*LINE_LENGTH nibbles per fill.
REQ-003 Parameter DUMMY, default 6: quad read mode plus dummy SCLK periods.
REQ-004 clk  in  1  the single clock; every flop is on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 pull  in  1  fill request (the cache missed).
REQ-007 tag  in  PA-log2(LINE_LENGTH)  line address of the miss.
REQ-008 dread  out  4  fill nibble to the cache.
REQ-009 wstrobe_d  out  1  dread is valid this cycle.
REQ-010 busy  out  1  a fill is in progress; the requester holds paddr stable while it is high.
REQ-011 sclk  out  1  QSPI serial clock.
REQ-012 cs_n  out  1  QSPI chip select, active low.
REQ-013 io_out  out  4  QSPI data out.
REQ-014 io_oe  out  4  per-pin output enable.
REQ-015 io_in  in  4  QSPI data in.

Function
REQ-016 States: IDLE, CMD, ADDR, DUMMY, DATA, BURST, GAP.
REQ-017 Each SCLK period is 2 clk:
- phase 0: sclk=0, outputs update.
- phase 1: sclk=1.
- io_in is sampled on the clk edge that ends phase 1.
REQ-018 IDLE with pull=1 latches tag and moves to CMD; cs_n goes low and busy goes high on that same edge.
REQ-019 CMD sends 8'hEB MSB first on io_out[0]; io_oe=4'b0001; lasts 8 periods.
REQ-020 ADDR sends a 24-bit byte address, {tag, log2(LINE_LENGTH) zero bits} zero-extended, high nibble first; io_oe=4'hF; lasts 6 periods.
REQ-021 DUMMY: io_oe=4'h0; lasts DUMMY periods.
REQ-022 DATA samples 2*LINE_LENGTH nibbles into a shift buffer in arrival order; io_oe=4'h0.
REQ-023 After the last DATA sample, cs_n goes high and the block enters BURST.
REQ-024 BURST asserts wstrobe_d for exactly 2*LINE_LENGTH consecutive clk cycles, with no gap, presenting nibbles in arrival order. The cache resets its nibble counter on any strobe gap.
REQ-025 GAP lasts 2 clk, then IDLE.
- pull is ignored during GAP, because the cache's hit output updates one cycle after the final strobe.
- busy drops on entry to IDLE.
REQ-026 pull is ignored in every state other than IDLE; a request is never queued.
REQ-027 pull held high in IDLE after GAP starts a new fill, because the cache still missed.
REQ-028 io_oe is 4'h0 whenever cs_n=1.
REQ-029 sclk is 0 whenever cs_n=1.
REQ-030 With DUMMY=6 and LINE_LENGTH=4, the first wstrobe_d occurs 57 clk after the edge that samples pull.

Reset
REQ-031 reset=0 asynchronously forces:
- IDLE, cs_n=1, sclk=0;
- io_out=0, io_oe=0;
- wstrobe_d=0, dread=0, busy=0;
- buffer and counters to 0.
REQ-032 Reset mid-fill aborts with no further strobes; after release, the block waits in IDLE for pull.

Structure
REQ-033 The shared package icache_pkg holds:
- the state enum;
- QSPI_CMD_QREAD=8'hEB;
- ADDR_NIBBLES=6.
REQ-034 Single module with one down-counter for periods, nibbles and burst; no sub-module.

Verification
REQ-035 Reset: assert reset=0 mid-DATA -> cs_n=1, io_oe=0, no wstrobe_d after release until a new pull.
REQ-036 Basic fill:
- stimulus: pull=1, tag=20'h00123, flash model returns nibbles 1..8;
- required: io_out[0] serialises 8'hEB, then address nibbles 0,0,0,4,8,C;
- required: dread sequence 1,2,3,4,5,6,7,8 on 8 consecutive strobes, first strobe at clk 57.
REQ-037 Against the real icache:
- stimulus: miss at paddr 22'h000010, memory word 32'hDEADBEEF;
- required: hit=1 one cycle after the last strobe, and rdata matches memory order for paddr[1]=0 and paddr[1]=1.
REQ-038 Back-to-back: pull held high across GAP -> exactly one fill per miss; second fill starts 2 clk after BURST ends.
REQ-039 pull pulsed during CMD/DATA/BURST -> ignored; tag latched at start is unchanged.
REQ-040 Protocol checker (assertions):
- sclk and io_oe idle while cs_n=1;
- wstrobe_d run length is exactly 8 in every fill.
